// File: rtl/afifo_rd_packer.sv
// Async-FIFO read-side packer: pops bytes from a show-ahead FIFO and packs
// LANES of them into one word, with flush and idle-timeout partial emission.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rempty, rdata       FIFO head status and data (show-ahead)
//   rinc                pop strobe toward the FIFO
//   flush               request to emit a partially filled word
//   out_data, out_keep  packed word (lane 0 in LSBs) and contiguous lane mask
//   out_valid/out_ready output handshake
module afifo_rd_packer #(
    parameter int D_WIDTH = 8,
    parameter int LANES   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rempty,
    input  logic [D_WIDTH-1:0]         rdata,
    output logic                       rinc,
    input  logic                       flush,
    output logic [D_WIDTH*LANES-1:0]   out_data,
    output logic [LANES-1:0]           out_keep,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int CW = $clog2(LANES) + 1;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [7:0]                      idle_cnt_q, idle_cnt_d;
    logic [LANES-1:0][D_WIDTH-1:0]   lane_q, lane_d;
    logic [LANES-1:0]                keep_q, keep_d;
    logic                            pop;

    // Mask with the lowest n lanes set.
    function automatic logic [LANES-1:0] low_mask(input logic [CW-1:0] n);
        logic [LANES-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            m[i] = (CW'(i) < n);
        end
        return m;
    endfunction

    // rst_n gates the strobe so the FIFO is never popped while in reset.
    assign pop       = rst_n && (state_q == FILL) && !rempty;
    assign rinc      = pop;
    assign out_valid = (state_q == HOLD);
    assign out_data  = lane_q;
    assign out_keep  = keep_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idle_cnt_d = idle_cnt_q;
        lane_d     = lane_q;
        keep_d     = keep_q;
        unique case (state_q)
            FILL: begin
                if (pop) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (CW'(i) == cnt_q) begin
                            lane_d[i] = rdata;
                        end
                    end
                    idle_cnt_d = '0;
                    cnt_d      = cnt_q + CW'(1);
                    // A flush that coincides with a pop includes that byte.
                    if (cnt_q == CW'(LANES - 1) || flush) begin
                        state_d = HOLD;
                        keep_d  = low_mask(cnt_q + CW'(1));
                    end
                end else if (cnt_q != '0) begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                    if (flush || idle_cnt_d == 8'(TIMEOUT)) begin
                        state_d    = HOLD;
                        keep_d     = low_mask(cnt_q);
                        idle_cnt_d = '0;
                    end
                end
            end
            HOLD: begin
                idle_cnt_d = '0;
                if (out_ready) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    lane_d  = '0;
                    keep_d  = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            idle_cnt_q <= '0;
            lane_q     <= '0;
            keep_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idle_cnt_q <= idle_cnt_d;
            lane_q     <= lane_d;
            keep_q     <= keep_d;
        end
    end

endmodule

// File: tb/tb_afifo_rd_packer.sv
// Bench for afifo_rd_packer: FIFO emulation, queue-based reference model,
// per-cycle comparison plus directed literal checks.
module tb_afifo_rd_packer;

    localparam int DW = 8;
    localparam int LN = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          rempty;
    logic [DW-1:0] rdata;
    logic          rinc;
    logic          flush = 1'b0;
    logic [31:0]   out_data;
    logic [3:0]    out_keep;
    logic          out_valid;
    logic          out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] fmem [0:255];
    int         head = 0;
    int         tail = 0;
    logic       hide = 1'b0;

    logic [7:0] mq[$];
    logic [7:0] hq[$];
    logic [7:0] out_s[$];
    logic [7:0] in_s[$];
    bit         m_hold = 1'b0;
    int         m_idle = 0;
    int         pops = 0;
    logic       rinc_s = 1'b0;

    assign rempty = hide || (head == tail);
    assign rdata  = fmem[head[7:0]];

    afifo_rd_packer #(
        .D_WIDTH (DW),
        .LANES   (LN),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .flush     (flush),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference model: bytes collected, word held, idle count.
    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            hq.delete();
            m_hold = 1'b0;
            m_idle = 0;
        end else begin
            if (rinc_s && !rempty) begin
                head <= head + 1;
                pops = pops + 1;
            end
            if (m_hold) begin
                m_idle = 0;
                if (out_ready) begin
                    foreach (hq[i]) out_s.push_back(hq[i]);
                    hq.delete();
                    m_hold = 1'b0;
                end
            end else if (!rempty) begin
                mq.push_back(rdata);
                m_idle = 0;
                if (mq.size() == LN || flush) begin
                    hq = mq;
                    mq.delete();
                    m_hold = 1'b1;
                end
            end else if (mq.size() > 0) begin
                m_idle = m_idle + 1;
                if (flush || m_idle == TO) begin
                    hq = mq;
                    mq.delete();
                    m_hold = 1'b1;
                    m_idle = 0;
                end
            end
        end
    end

    // Per-cycle comparison, sampled on the falling edge.
    always begin
        logic [31:0] ew;
        logic [3:0]  ek;
        @(negedge clk);
        rinc_s = rinc;
        if (!rst_n) begin
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_data", out_data, 32'd0);
            chk("rst_keep", 32'(out_keep), 32'd0);
            chk("rst_rinc", 32'(rinc), 32'd0);
        end else begin
            chk("valid", 32'(out_valid), 32'(m_hold));
            chk("rinc", 32'(rinc), 32'(!m_hold && !rempty));
            if (m_hold) begin
                ew = '0;
                foreach (hq[i]) ew = ew | (32'(hq[i]) << (8 * i));
                ek = 4'((1 << hq.size()) - 1);
                chk("data", out_data, ew);
                chk("keep", 32'(out_keep), 32'(ek));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fmem[tail[7:0]] = b;
        tail = tail + 1;
    endtask

    task automatic wait_valid(input int max, input string nm);
        int k;
        k = 0;
        while (!out_valid && k < max) begin
            cyc(1);
            k++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s: out_valid got 0 expected 1 within %0d cycles",
                     nm, max);
        end
    endtask

    task automatic release_word();
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        int base;
        logic [7:0] b;

        #2 rst_n = 1'b0;
        cyc(2);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_data", out_data, 32'd0);
        chk("reset_keep", 32'(out_keep), 32'd0);
        rst_n = 1'b1;
        cyc(1);

        // Full word
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_valid(10, "full_wait");
        chk("full_pops", 32'(pops), 32'd4);
        chk("full_data", out_data, 32'h44332211);
        chk("full_keep", 32'(out_keep), 32'hF);

        // Backpressure with a byte waiting
        push(8'h55);
        cyc(10);
        chk("bp_data", out_data, 32'h44332211);
        chk("bp_keep", 32'(out_keep), 32'hF);
        chk("bp_pops", 32'(pops), 32'd4);
        release_word();
        chk("bp_drop", 32'(out_valid), 32'd0);
        cyc(1);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        chk("bp_lane0_data", out_data, 32'h00000055);
        chk("bp_lane0_keep", 32'(out_keep), 32'h1);
        release_word();

        // Idle timeout flush
        push(8'hAA); push(8'hBB);
        cyc(16);
        chk("to_early", 32'(out_valid), 32'd0);
        cyc(1);
        chk("to_valid", 32'(out_valid), 32'd1);
        chk("to_data", out_data, 32'h0000BBAA);
        chk("to_keep", 32'(out_keep), 32'h3);
        release_word();

        // Flush with nothing captured
        flush = 1'b1;
        cyc(3);
        chk("flush_empty", 32'(out_valid), 32'd0);
        flush = 1'b0;

        // Flush coinciding with the third pop
        push(8'h11); push(8'h22); push(8'h33);
        cyc(2);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        chk("fpop_valid", 32'(out_valid), 32'd1);
        chk("fpop_data", out_data, 32'h00332211);
        chk("fpop_keep", 32'(out_keep), 32'h7);

        // Reset mid-HOLD
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_data", out_data, 32'd0);
        chk("mrst_keep", 32'(out_keep), 32'd0);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        #1;
        chk("mrst_rinc", 32'(rinc), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        wait_valid(10, "mrst_wait");
        chk("mrst_word", out_data, 32'h04030201);
        chk("mrst_wkeep", 32'(out_keep), 32'hF);
        release_word();

        // Streaming with random gaps
        base = out_s.size();
        n = 0;
        for (int it = 0; it < 2000 && n < 64; it++) begin
            hide = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1) begin
                b = 8'($urandom_range(0, 255));
                push(b);
                in_s.push_back(b);
                n++;
            end
            cyc(1);
        end
        hide = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while (k < 300 &&
               !(head == tail && !m_hold && mq.size() == 0 && !out_valid)) begin
            cyc(1);
            k++;
        end
        out_ready = 1'b0;
        chk("stream_drained", 32'(k < 300), 32'd1);
        chk("stream_len", 32'(out_s.size() - base), 32'd64);
        for (int i = 0; i < 64; i++) begin
            if (base + i < out_s.size()) begin
                chk("stream_byte", 32'(out_s[base + i]), 32'(in_s[i]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
